// File: rtl/wallace_mul_arbiter.sv
// Round-robin front end that time-shares one external 8x8 combinational multiplier
// between NUM_REQ requesters and returns each product with its owner's ID.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready are both 1.
// A producer holds valid and its payload stable until that edge. Ready on the request
// side is a combinational function of req_valid, rr_ptr and state. Ready on the
// response side may be driven freely by the consumer.
module wallace_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int MUL_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [8*NUM_REQ-1:0] req_a,
  input  logic [8*NUM_REQ-1:0] req_b,
  output logic [7:0]           mul_a,
  output logic [7:0]           mul_b,
  input  logic [16:0]          mul_p,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [15:0]          rsp_data,
  output logic                 rsp_err,
  output logic                 busy
);

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant_idx;
  logic            grant_found;
  logic [7:0]      sel_a;
  logic [7:0]      sel_b;
  logic [CNT_W-1:0] cnt;
  logic            req_fire;
  logic            calc_done;
  logic            rsp_fire;

  // Search upward from rr_ptr, wrapping at NUM_REQ so unused ID codes are never granted.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    sel_a       = '0;
    sel_b       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(idx);
        sel_a       = req_a[idx*8 +: 8];
        sel_b       = req_b[idx*8 +: 8];
      end
    end
  end

  assign req_fire  = (state == IDLE) && grant_found;
  assign calc_done = (state == CALC) && (cnt == '0);
  assign rsp_fire  = (state == RESP) && rsp_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_fire)  state_nxt = CALC;
      CALC:    if (calc_done) state_nxt = RESP;
      RESP:    if (rsp_fire)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs; req_ready is also forced low while reset is held.
  always_comb begin
    busy      = (state != IDLE);
    req_ready = '0;
    if ((state == IDLE) && grant_found && rst_n)
      req_ready = NUM_REQ'(1) << grant_idx;
  end

  // Datapath: operand latch, settle counter, response capture, pointer update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (req_fire) begin
        mul_a  <= sel_a;
        mul_b  <= sel_b;
        rsp_id <= grant_idx;
        cnt    <= CNT_W'(MUL_LAT - 1);
        rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : ID_W'(grant_idx + 1'b1);
      end else if ((state == CALC) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end

      if (calc_done) begin
        rsp_data  <= mul_p[15:0];
        rsp_err   <= mul_p[16];
        rsp_valid <= 1'b1;
      end else if (rsp_fire) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wallace_mul_arbiter.sv
// Directed bench for wallace_mul_arbiter: one instance with a 1-cycle settle time and
// one with 3 cycles, each fed by a behavioural multiplier model.
module tb_wallace_mul_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // ---------------- DUT with MUL_LAT=1 ----------------
  logic [3:0]  req_valid, req_ready;
  logic [31:0] req_a, req_b;
  logic [7:0]  mul_a, mul_b;
  logic [16:0] mul_p;
  logic        rsp_valid, rsp_ready, rsp_err, busy;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_data;
  logic        err_force;

  assign mul_p = {err_force, {8'd0, mul_a} * {8'd0, mul_b}};

  wallace_mul_arbiter #(.NUM_REQ(4), .ID_W(2), .MUL_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy)
  );

  // ---------------- DUT with MUL_LAT=3 ----------------
  logic [3:0]  req3_valid, req3_ready;
  logic [31:0] req3_a, req3_b;
  logic [7:0]  mul3_a, mul3_b;
  logic [16:0] mul3_p;
  logic        rsp3_valid, rsp3_ready, rsp3_err, busy3;
  logic [1:0]  rsp3_id;
  logic [15:0] rsp3_data;

  assign mul3_p = {1'b0, {8'd0, mul3_a} * {8'd0, mul3_b}};

  wallace_mul_arbiter #(.NUM_REQ(4), .ID_W(2), .MUL_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req3_valid), .req_ready(req3_ready),
    .req_a(req3_a), .req_b(req3_b),
    .mul_a(mul3_a), .mul_b(mul3_b), .mul_p(mul3_p),
    .rsp_valid(rsp3_valid), .rsp_ready(rsp3_ready),
    .rsp_id(rsp3_id), .rsp_data(rsp3_data), .rsp_err(rsp3_err),
    .busy(busy3)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [19:0] exp_q[$];
  logic [19:0] exp_e;
  int n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counts falling edges until the selected instance shows rsp_valid, bounded at 20.
  task automatic wait_rsp(input bit slow, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (((slow ? rsp3_valid : rsp_valid) !== 1'b1) && (cnt < 20));
    if ((slow ? rsp3_valid : rsp_valid) !== 1'b1) begin
      total++;
      bad++;
      $error("FAIL rsp_timeout: observed=no response expected=response within 20 cycles");
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=bench end");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0; err_force = 1'b0;
    req_valid = 4'b0001; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    req3_valid = '0; req3_a = '0; req3_b = '0; rsp3_ready = 1'b1;

    // Reset values, with a request pending to show req_ready stays low in reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_busy",      32'(busy),      32'h0);
    chk("rst_mul_a",     32'(mul_a),     32'h0);
    chk("rst_mul_b",     32'(mul_b),     32'h0);
    chk("rst_rsp_id",    32'(rsp_id),    32'h0);
    chk("rst_rsp_data",  32'(rsp_data),  32'h0);
    chk("rst_rsp_err",   32'(rsp_err),   32'h0);

    // Single request 255*255
    @(posedge clk); #1;
    rst_n = 1'b1; req_a[7:0] = 8'd255; req_b[7:0] = 8'd255;
    @(negedge clk);
    chk("t1_grant", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid = 4'b0000;
    @(negedge clk);
    chk("t1_ready_drop", 32'(req_ready), 32'h0);
    chk("t1_busy",       32'(busy),      32'h1);
    chk("t1_mul_a",      32'(mul_a),     32'hFF);
    chk("t1_mul_b",      32'(mul_b),     32'hFF);
    wait_rsp(1'b0, n);
    chk("t1_latency", 32'(n + 1), 32'd2);
    chk("t1_data",    32'(rsp_data), 32'hFE01);
    chk("t1_id",      32'(rsp_id),   32'h0);
    chk("t1_err",     32'(rsp_err),  32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("t1_rsp_done", 32'(rsp_valid), 32'h0);
    chk("t1_idle",     32'(busy),      32'h0);
    chk("t1_hold_a",   32'(mul_a),     32'hFF);

    // Reset pulse so the pointer (now 1) returns to 0
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;

    // All four requesting continuously: a=i+1, b=10
    req_valid = 4'b1111;
    req_a = {8'd4, 8'd3, 8'd2, 8'd1};
    req_b = {4{8'd10}};
    exp_q.push_back({4'd0, 16'd10});
    exp_q.push_back({4'd1, 16'd20});
    exp_q.push_back({4'd2, 16'd30});
    exp_q.push_back({4'd3, 16'd40});
    exp_q.push_back({4'd0, 16'd10});
    for (int t = 0; t < 5; t++) begin
      exp_e = exp_q.pop_front();
      @(negedge clk);
      chk("rr_grant", 32'(req_ready), 32'(4'b0001 << exp_e[19:16]));
      @(posedge clk);
      wait_rsp(1'b0, n);
      chk("rr_latency", 32'(n), 32'd2);
      chk("rr_data",    32'(rsp_data), 32'(exp_e[15:0]));
      chk("rr_id",      32'(rsp_id),   32'(exp_e[19:16]));
      @(posedge clk);
    end

    // Backpressure on requester 1's response
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp_grant", 32'(req_ready), 32'h2);
    @(posedge clk);
    wait_rsp(1'b0, n);
    chk("bp_data0", 32'(rsp_data), 32'd20);
    chk("bp_id0",   32'(rsp_id),   32'd1);
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      chk("bp_valid", 32'(rsp_valid), 32'h1);
      chk("bp_data",  32'(rsp_data),  32'd20);
      chk("bp_id",    32'(rsp_id),    32'd1);
      chk("bp_busy",  32'(busy),      32'h1);
      chk("bp_ready", 32'(req_ready), 32'h0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_still_valid", 32'(rsp_valid), 32'h1);
    @(posedge clk); #1 req_valid = 4'b0000;
    @(negedge clk);
    chk("bp_done_valid", 32'(rsp_valid), 32'h0);
    chk("bp_done_busy",  32'(busy),      32'h0);

    // Error flag forced on the product, then a clean operation
    @(posedge clk); #1;
    err_force = 1'b1; req_valid = 4'b0100; req_a[23:16] = 8'd3; req_b[23:16] = 8'd5;
    @(negedge clk);
    chk("err_grant", 32'(req_ready), 32'h4);
    @(posedge clk); #1 req_valid = 4'b0000;
    wait_rsp(1'b0, n);
    chk("err_data", 32'(rsp_data), 32'd15);
    chk("err_flag", 32'(rsp_err),  32'h1);
    @(posedge clk); #1;
    err_force = 1'b0; req_valid = 4'b0100; req_a[23:16] = 8'd7; req_b[23:16] = 8'd9;
    @(negedge clk);
    chk("clr_grant", 32'(req_ready), 32'h4);
    @(posedge clk); #1 req_valid = 4'b0000;
    wait_rsp(1'b0, n);
    chk("clr_data", 32'(rsp_data), 32'd63);
    chk("clr_flag", 32'(rsp_err),  32'h0);
    @(posedge clk);

    // Reset during CALC: pointer would be 3 afterwards without the reset
    #1 req_valid = 4'b0100; req_a[23:16] = 8'd9; req_b[23:16] = 8'd9;
    @(posedge clk); #1 req_valid = 4'b0000;
    @(negedge clk);
    chk("mid_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("mid_busy_rst",  32'(busy),      32'h0);
    chk("mid_mul_a",     32'(mul_a),     32'h0);
    chk("mid_mul_b",     32'(mul_b),     32'h0);
    chk("mid_rsp_id",    32'(rsp_id),    32'h0);
    chk("mid_rsp_data",  32'(rsp_data),  32'h0);
    chk("mid_rsp_err",   32'(rsp_err),   32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("mid_no_rsp", 32'(rsp_valid), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1; req_valid = 4'b1100; req_a[31:24] = 8'd5; req_b[31:24] = 8'd5;
    @(negedge clk);
    chk("post_rst_grant", 32'(req_ready), 32'h4);
    chk("post_rst_valid", 32'(rsp_valid), 32'h0);
    @(posedge clk); #1 req_valid = 4'b1000;
    wait_rsp(1'b0, n);
    chk("post_rst_data", 32'(rsp_data), 32'd81);
    chk("post_rst_id",   32'(rsp_id),   32'd2);
    @(posedge clk); #1 req_valid = 4'b0000;

    // MUL_LAT=3 instance: 200*3
    req3_valid = 4'b0001; req3_a[7:0] = 8'd200; req3_b[7:0] = 8'd3;
    @(negedge clk);
    chk("lat3_grant", 32'(req3_ready), 32'h1);
    @(posedge clk); #1 req3_valid = 4'b0000;
    wait_rsp(1'b1, n);
    chk("lat3_latency", 32'(n), 32'd4);
    chk("lat3_data",    32'(rsp3_data), 32'd600);
    chk("lat3_id",      32'(rsp3_id),   32'd0);
    chk("lat3_err",     32'(rsp3_err),  32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("lat3_done",   32'(rsp3_valid), 32'h0);
    chk("lat3_idle",   32'(busy3),      32'h0);
    chk("lat3_hold_a", 32'(mul3_a),     32'd200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
